// File: rtl/fc_ctrl_pkg.sv
// fc_ctrl_pkg: shared sizes, widths and state encoding for the dense-layer sequencer
package fc_ctrl_pkg;
    localparam int INPUT_NUM  = 144;
    localparam int OUTPUT_NUM = 10;
    localparam int LANES      = 9;
    localparam int BEATS      = INPUT_NUM / LANES;
    localparam int ADDR_W     = 11;
    localparam int ACC_W      = 20;
    localparam int IDX_W      = 4;
    localparam int BEAT_W     = $clog2(BEATS);
    typedef enum logic [1:0] {S_FILL, S_MAC, S_BIAS, S_EMIT} state_t;
endpackage

// File: rtl/fc_layer_sequencer_if.sv
// fc_layer_sequencer_if: feature input, buffer/MAC control and result handshake of the dense-layer sequencer
interface fc_layer_sequencer_if;
    import fc_ctrl_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic              buf_wr_en;
    logic [BEAT_W-1:0] buf_wr_addr;
    logic [BEAT_W-1:0] mac_rd_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              acc_clr;
    logic              acc_en;
    logic              bias_en;
    logic [IDX_W-1:0]  neuron_idx;
    logic [ACC_W-1:0]  acc_in;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic              frame_done;
    logic [IDX_W-1:0]  class_idx;
    logic              class_valid;
    logic              busy;
    modport master (
        input  in_valid, acc_in, out_ready,
        output in_ready, buf_wr_en, buf_wr_addr, mac_rd_addr, w_rd_addr, acc_clr, acc_en,
               bias_en, neuron_idx, out_valid, out_idx, frame_done, class_idx, class_valid, busy
    );
    modport slave (
        output in_valid, acc_in, out_ready,
        input  in_ready, buf_wr_en, buf_wr_addr, mac_rd_addr, w_rd_addr, acc_clr, acc_en,
               bias_en, neuron_idx, out_valid, out_idx, frame_done, class_idx, class_valid, busy
    );
endinterface

// File: rtl/fc_argmax_tracker.sv
// fc_argmax_tracker: running signed max over emitted neurons; ties keep the lower index
module fc_argmax_tracker
    import fc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             sample,
    input  logic             first,
    input  logic [ACC_W-1:0] value,
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] class_idx
);
    logic signed [ACC_W-1:0] max_val;
    // first neuron always loads, later ones only when strictly larger
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val   <= '0;
            class_idx <= '0;
        end else if (sample && (first || $signed(value) > max_val)) begin
            max_val   <= $signed(value);
            class_idx <= idx;
        end
    end
endmodule

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: FILL/MAC/BIAS/EMIT schedule for the time-multiplexed dense layer; ARGMAX_EN adds argmax output
module fc_layer_sequencer
    import fc_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    fc_layer_sequencer_if.master bus
);
    state_t            state;
    logic [BEAT_W-1:0] beat_cnt;
    logic              handshake;
    logic              last_neuron;
    assign bus.in_ready    = state == S_FILL;
    assign bus.buf_wr_en   = bus.in_valid && bus.in_ready;
    assign bus.buf_wr_addr = beat_cnt;
    assign bus.out_idx     = bus.neuron_idx;
    assign handshake       = state == S_EMIT && bus.out_ready;
    assign last_neuron     = bus.neuron_idx == IDX_W'(OUTPUT_NUM - 1);
    // sequencer FSM; every MAC control output is registered alongside the state it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_FILL;
            beat_cnt        <= '0;
            bus.mac_rd_addr <= '0;
            bus.w_rd_addr   <= '0;
            bus.acc_clr     <= 1'b0;
            bus.acc_en      <= 1'b0;
            bus.bias_en     <= 1'b0;
            bus.neuron_idx  <= '0;
            bus.out_valid   <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            case (state)
                S_FILL: if (bus.in_valid) begin
                    bus.busy <= 1'b1;
                    if (beat_cnt == BEAT_W'(BEATS - 1)) begin
                        state           <= S_MAC;
                        beat_cnt        <= '0;
                        bus.mac_rd_addr <= '0;
                        bus.w_rd_addr   <= '0;
                        bus.acc_en      <= 1'b1;
                        bus.acc_clr     <= 1'b1;
                    end else
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                end
                S_MAC: begin
                    bus.acc_clr   <= 1'b0;
                    bus.w_rd_addr <= bus.w_rd_addr + ADDR_W'(LANES);
                    if (bus.mac_rd_addr == BEAT_W'(BEATS - 1)) begin
                        state           <= S_BIAS;
                        bus.mac_rd_addr <= '0;
                        bus.acc_en      <= 1'b0;
                        bus.bias_en     <= 1'b1;
                    end else
                        bus.mac_rd_addr <= bus.mac_rd_addr + BEAT_W'(1);
                end
                S_BIAS: begin
                    state         <= S_EMIT;
                    bus.bias_en   <= 1'b0;
                    bus.out_valid <= 1'b1;
                end
                S_EMIT: if (handshake) begin
                    bus.out_valid <= 1'b0;
                    if (last_neuron) begin
                        state          <= S_FILL;
                        bus.neuron_idx <= '0;
                        bus.frame_done <= 1'b1;
                        bus.busy       <= 1'b0;
                    end else begin
                        state          <= S_MAC;
                        bus.neuron_idx <= bus.neuron_idx + IDX_W'(1);
                        bus.acc_en     <= 1'b1;
                        bus.acc_clr    <= 1'b1;
                    end
                end
            endcase
        end
    end
`ifdef ARGMAX_EN
    fc_argmax_tracker u_argmax (
        .clk       (clk),
        .rst       (rst),
        .sample    (handshake),
        .first     (bus.neuron_idx == '0),
        .value     (bus.acc_in),
        .idx       (bus.neuron_idx),
        .class_idx (bus.class_idx)
    );
    // class_valid lines up with frame_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.class_valid <= 1'b0;
        else
            bus.class_valid <= handshake && last_neuron;
    end
`else
    assign bus.class_idx   = '0;
    assign bus.class_valid = 1'b0;
`endif
endmodule
